// File: rtl/serial_add_pkg.sv
// Shared types and default sizing for the serial-adder scheduler.
// Build option: define SAS_TIMEOUT_EN to enable the WAIT-state abort timer.
package serial_add_pkg;

  // Scheduler FSM states; one operation in flight at a time
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned SAS_NUM_REQ = 4;
  localparam int unsigned SAS_WIDTH   = 4;
  localparam int unsigned SAS_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward (with wrap) from last_grant+1 for the first set request bit.
//   req        in   NUM_REQ  request vector
//   last_grant in   IDX_W    index granted most recently (lowest priority now)
//   grant      out  NUM_REQ  one-hot grant, 0 when no request
//   grant_idx  out  IDX_W    index of the granted requester
//   any        out  1        at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Rotating priority search; the first hit wins
  always_comb begin
    int unsigned j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = (32'(last_grant) + k) % NUM_REQ;
      if (!any && req[IDX_W'(j)]) begin
        any       = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Shares one bit-serial adder among NUM_REQ requesters using round-robin.
// Flow: IDLE (grant + latch operands) -> ISSUE (add_start pulse) -> WAIT (add_done)
//       -> RESP (one-cycle rsp_valid pulse to the owner) -> IDLE.
// Build option: SAS_TIMEOUT_EN adds a TIMEOUT-cycle WAIT abort that reports rsp_error.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready combinational, one-hot)
//   req_a, req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_sum      one-hot result pulse and sum (registered)
//   rsp_error              result aborted by timeout (registered, 0 without SAS_TIMEOUT_EN)
//   busy                   scheduler not idle (registered)
//   add_start/add_a/add_b  adder request (registered)
//   add_done/add_sum       adder completion and result
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int unsigned NUM_REQ = SAS_NUM_REQ,
  parameter int unsigned WIDTH   = SAS_WIDTH,
  parameter int unsigned TIMEOUT = SAS_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     add_start,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic                     add_done,
  input  logic [WIDTH-1:0]         add_sum
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("serial_add_scheduler: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Accept only while idle; the arbiter result is the one-hot ready
  assign req_ready = (state == IDLE) ? arb_grant : '0;

  // Operands of the requester being granted this cycle
  assign sel_a = req_a[arb_idx*WIDTH +: WIDTH];
  assign sel_b = req_b[arb_idx*WIDTH +: WIDTH];

`ifdef SAS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] wait_cnt;
`else
  assign rsp_error = 1'b0;
`endif

  // Scheduler FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_start  <= 1'b0;
      rsp_valid  <= '0;
      rsp_sum    <= '0;
      busy       <= 1'b0;
`ifdef SAS_TIMEOUT_EN
      rsp_error  <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      add_start <= 1'b0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
`ifdef SAS_TIMEOUT_EN
      rsp_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb_any) begin
            owner     <= arb_idx;
            add_a     <= sel_a;
            add_b     <= sel_b;
            add_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SAS_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // add_done on the expiry cycle still delivers the normal result
          if (add_done) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_sum   <= add_sum;
            state     <= RESP;
          end
`ifdef SAS_TIMEOUT_EN
          else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_error <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
